// File: rtl/mm_result_collector.sv
// Collects LSW-first Montgomery result words, optionally subtracts p once (MM_FINAL_SUB_EN), then presents res_out with a one-cycle res_valid pulse.
// Latency after the last word is NUM_WORDS+1 cycles with MM_FINAL_SUB_EN and 1 cycle without. There is no backpressure: every s_valid word is taken.
module mm_result_collector #(
  parameter int RADIX     = 32,
  parameter int NUM_WORDS = 12
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       start,
  input  logic [RADIX*NUM_WORDS-1:0] p_in,
  input  logic                       s_valid,
  input  logic [RADIX-1:0]           s_word,
  input  logic                       carry_in,
  output logic                       busy,
  output logic                       res_valid,
  output logic [RADIX*NUM_WORDS-1:0] res_out
);
  localparam int W  = RADIX * NUM_WORDS;
  localparam int CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_WORDS - 1);

  typedef enum logic [1:0] {IDLE, COLLECT, SUB, DONE} state_t;

`ifdef MM_FINAL_SUB_EN
  localparam state_t COLLECT_EXIT = SUB;
`else
  localparam state_t COLLECT_EXIT = DONE;
`endif

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic             carry_q;
  logic [RADIX-1:0] s_mem [NUM_WORDS];
  logic [W-1:0]     s_flat;
  logic [W-1:0]     res_sel;
  logic             last_word;

  assign last_word = (cnt == LAST);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // start has priority over everything, including a word arriving in the same cycle
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        IDLE:    state_nxt = IDLE;
        COLLECT: if (s_valid && last_word) state_nxt = COLLECT_EXIT;
        SUB:     if (last_word) state_nxt = DONE;
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) s_mem[i] <= '0;
    end else if (start) begin
      cnt     <= '0;
      carry_q <= 1'b0;
    end else if (state == COLLECT && s_valid) begin
      s_mem[cnt] <= s_word;
      if (last_word) begin
        cnt     <= '0;
        carry_q <= carry_in;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end else if (state == SUB) begin
      cnt <= last_word ? '0 : cnt + CW'(1);
    end
  end

  always_comb begin
    s_flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) s_flat[i*RADIX +: RADIX] = s_mem[i];
  end

`ifdef MM_FINAL_SUB_EN
  logic [RADIX-1:0] d_mem [NUM_WORDS];
  logic [W-1:0]     d_flat;
  logic             borrow_q;
  logic [RADIX:0]   diff;

  // The extra top bit of the difference is the outgoing borrow
  assign diff = {1'b0, s_mem[cnt]} - {1'b0, p_in[int'(cnt)*RADIX +: RADIX]}
              - {{RADIX{1'b0}}, borrow_q};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      borrow_q <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) d_mem[i] <= '0;
    end else if (start) begin
      borrow_q <= 1'b0;
    end else if (state == SUB) begin
      d_mem[cnt] <= diff[RADIX-1:0];
      borrow_q   <= diff[RADIX];
    end
  end

  always_comb begin
    d_flat = '0;
    for (int i = 0; i < NUM_WORDS; i++) d_flat[i*RADIX +: RADIX] = d_mem[i];
  end

  // carry set or no final borrow means carry*2^W + S >= p, so take the difference
  assign res_sel = (carry_q || !borrow_q) ? d_flat : s_flat;
`else
  logic unused_cfg;
  assign unused_cfg = ^{p_in, carry_q};
  assign res_sel    = s_flat;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      res_valid <= 1'b0;
      res_out   <= '0;
    end else begin
      res_valid <= (state == DONE);
      if (state == DONE) res_out <= res_sel;
    end
  end
endmodule

// File: doc/mm_result_collector.md
# mm_result_collector

Word-serial result collector for the Montgomery multiplier systolic array. Accepts the RADIX-bit result words and final carry emitted by the last processing element, least-significant word first. Applies the final conditional subtraction of the modulus one word per cycle and presents the fully reduced product as a parallel word to the ECC datapath, with a one-cycle valid pulse.

## Interface
- RADIX, 32, word width in bits; must match the PE word width
- NUM_WORDS, 12, words per operand (operand width = RADIX*NUM_WORDS, 384 by default)
- clk  input  1  clock, all state on rising edge
- reset_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; clears state and arms collection of a new result
- p_in  input  RADIX*NUM_WORDS  modulus; must be stable from start until res_valid
- s_valid  input  1  s_word is valid this cycle
- s_word  input  RADIX  result word from last PE, LSW first
- carry_in  input  1  final carry bit (bit RADIX of last PE carry); sampled together with the last word
- busy  output  1  high in COLLECT, SUB and DONE
- res_valid  output  1  one-cycle pulse; res_out is updated on the same edge
- res_out  output  RADIX*NUM_WORDS  reduced result; held until next res_valid

## Operation
- States: IDLE, COLLECT, SUB, DONE. Word counter cnt has width $clog2(NUM_WORDS) (minimum 1).
- IDLE: start -> COLLECT with cnt=0, carry register=0, borrow=0. s_valid is ignored.
- COLLECT: each cycle with s_valid=1, s_word is stored at word index cnt and cnt increments.
  - When s_valid=1 and cnt==NUM_WORDS-1, carry_in is also sampled into the carry register.
  - Same cycle: with the macro, go to SUB and set cnt=0; without it, go to DONE.
  - Gaps in s_valid are allowed; no timeout.
- SUB: each cycle, d[cnt] = s[cnt] - p[cnt] - borrow, modulo 2^RADIX. Borrow is set from the (RADIX+1)-bit difference. cnt increments.
  - After word NUM_WORDS-1 is processed, go to DONE.
- DONE (one cycle): res_out <= (carry==1 || final borrow==0) ? d : s. res_valid=1. Go to IDLE.
- Arithmetic: the true value is carry*2^(RADIX*NUM_WORDS) + S. The selection yields exactly one subtraction of p when value ≥ p. The input guarantees value < 2p.
- start in any state (including COLLECT, SUB, DONE) aborts the current operation and re-enters COLLECT with cnt=0.
  - A start in DONE still lets res_valid/res_out occur on that edge; the new collection then begins.
- s_valid together with start in the same cycle: the word is dropped, because start has priority.

## Timing
- Reset values: busy=0, res_valid=0, res_out=0, state IDLE, cnt=0, all internal word/carry/borrow registers 0.
- Reset asserted mid-operation returns to IDLE immediately, with no res_valid.
- busy rises on the edge after start and falls on the edge after DONE.
- Latency with macro: last word accepted at edge T -> res_valid high during cycle T+NUM_WORDS+1.
- Latency without macro: res_valid high during cycle T+1.
- Minimum start-to-res_valid interval with macro and back-to-back words: 2*NUM_WORDS+1 cycles.

## Configuration
- MM_FINAL_SUB_EN defined: the SUB state, d storage and borrow logic are present; res_out is fully reduced, in [0,p).
- MM_FINAL_SUB_EN undefined: SUB is removed and p_in is unused. COLLECT goes directly to DONE and res_out = s (lower RADIX*NUM_WORDS bits), in [0,2p).
  - carry_in is still captured, but it does not affect res_out.

## Test plan
All cases use RADIX=32, NUM_WORDS=2, p=0x00000001_00000005, with the macro defined unless stated.
- Words 0x00000003, 0x00000000, carry 0 -> res_out=0x00000000_00000003, res_valid exactly 3 cycles after the last word edge.
- Words 0x00000007, 0x00000001, carry 0 -> res_out=0x00000000_00000002.
- Words 0x00000005, 0x00000001 (S=p), carry 0 -> res_out=0.
- Words 0x00000002, 0x00000000, carry 1 -> res_out=0xFFFFFFFE_FFFFFFFD.
- start, one word 0xDEADBEEF, then start again, then words 0x7 and 0x1 with carry 0 -> single res_valid with res_out=0x2; reset_n pulsed mid-SUB -> no res_valid, all outputs 0.
- Macro undefined: words 0x00000007, 0x00000001 -> res_out=0x00000001_00000007, res_valid 1 cycle after the last word.
